ysyx_23060124_mem_stage: RTL

Multi-cycle memory-access stage directly downstream of the execute stage. Consumes the ALU result (effective address or plain result), store data (rs2), load/store opcodes and rd index. Performs at most one word-bus transaction per instruction. Hands aligned, extended write-back data to the write-back stage over a valid/ready handshake.

---
 rtl/ysyx_23060124_mem_stage.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060124_mem_stage.sv
// ysyx_23060124_mem_stage
//
// Multi-cycle memory-access stage that sits after execute. It accepts one
// instruction at a time and issues at most one word-bus transaction for it.
// It then hands aligned, extended write-back data to the write-back stage.
//
// Ports
//   clk, i_rst             clock; synchronous active-high reset
//   i_valid / o_ready      upstream handshake (accept when both high)
//   i_alu_res, i_wdata     effective address / ALU result, store source (rs2)
//   i_load_opt             0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU
//   i_store_opt            0 none, 1 SB, 2 SH, 3 SW
//   i_rd, i_rd_wen         destination register and its write enable
//   o_mem_*                word bus request: req, we, aligned addr, lane data, strobes
//   i_mem_gnt              request accepted this cycle
//   i_mem_rvalid/_rdata    read response
//   o_valid / i_ready      downstream handshake to write-back
//   o_wb_data, o_rd, o_wb_en, o_misalign   write-back payload
//   state_dbg              current FSM state (0 IDLE, 1 REQ, 2 WAIT_R, 3 DONE)
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Once o_valid is raised, the payload holds until i_ready is
// seen. A bus request holds addr/we/wdata/wstrb until i_mem_gnt is seen.
// i_mem_rvalid is only honoured in WAIT_R, which is the cycle after the grant
// or later.

module ysyx_23060124_mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int OPT_W  = 3
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [ADDR_W-1:0] i_alu_res,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [OPT_W-1:0]  i_load_opt,
    input  logic [OPT_W-1:0]  i_store_opt,
    input  logic [4:0]        i_rd,
    input  logic              i_rd_wen,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [3:0]        o_mem_wstrb,
    input  logic              i_mem_gnt,
    input  logic              i_mem_rvalid,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_wb_data,
    output logic [4:0]        o_rd,
    output logic              o_wb_en,
    output logic              o_misalign,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state;

    // Instruction context kept for the response phase.
    logic [OPT_W-1:0] load_opt_q;
    logic [1:0]       addr_lo_q;
    logic             rd_wen_q;

    // ---------------- accept-time decode ----------------
    logic acc_load;
    logic acc_store;
    logic acc_byte;
    logic acc_half;
    logic acc_word;
    logic acc_mis;

    // A load wins when both opcodes are set, so the store is masked off.
    assign acc_load  = (i_load_opt != '0);
    assign acc_store = !acc_load && (i_store_opt != '0);

    always_comb begin
        acc_byte = 1'b0;
        acc_half = 1'b0;
        if (acc_load) begin
            acc_byte = (i_load_opt == OPT_W'(1)) || (i_load_opt == OPT_W'(4));
            acc_half = (i_load_opt == OPT_W'(2)) || (i_load_opt == OPT_W'(5));
        end else if (acc_store) begin
            acc_byte = (i_store_opt == OPT_W'(1));
            acc_half = (i_store_opt == OPT_W'(2));
        end
    end

    assign acc_word = (acc_load || acc_store) && !acc_byte && !acc_half;
    assign acc_mis  = (acc_half && i_alu_res[0]) ||
                      (acc_word && (i_alu_res[1:0] != 2'b00));

    // Store lane formatting: data is replicated so the selected strobes
    // always find the right bytes regardless of offset.
    logic [DATA_W-1:0] st_wdata;
    logic [3:0]        st_strb;

    always_comb begin
        st_wdata = i_wdata;
        st_strb  = 4'b1111;
        if (acc_byte) begin
            st_wdata = {(DATA_W/8){i_wdata[7:0]}};
            st_strb  = 4'b0001 << i_alu_res[1:0];
        end else if (acc_half) begin
            st_wdata = {(DATA_W/16){i_wdata[15:0]}};
            st_strb  = i_alu_res[1] ? 4'b1100 : 4'b0011;
        end
    end

    // ---------------- load extraction ----------------
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_data;

    assign ld_byte = i_mem_rdata[{addr_lo_q, 3'b000} +: 8];
    assign ld_half = addr_lo_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

    always_comb begin
        ld_data = i_mem_rdata;
        case (load_opt_q)
            OPT_W'(1): ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            OPT_W'(2): ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
            OPT_W'(4): ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
            OPT_W'(5): ld_data = {{(DATA_W-16){1'b0}}, ld_half};
            default:   ld_data = i_mem_rdata;
        endcase
    end

    // ---------------- state machine ----------------
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state       <= IDLE;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_wstrb <= 4'b0000;
            o_wb_data   <= '0;
            o_rd        <= 5'd0;
            o_wb_en     <= 1'b0;
            o_misalign  <= 1'b0;
            load_opt_q  <= '0;
            addr_lo_q   <= 2'b00;
            rd_wen_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        o_rd        <= i_rd;
                        rd_wen_q    <= i_rd_wen;
                        addr_lo_q   <= i_alu_res[1:0];
                        load_opt_q  <= acc_load ? i_load_opt : '0;
                        o_mem_addr  <= {i_alu_res[ADDR_W-1:2], 2'b00};
                        o_mem_we    <= acc_store && !acc_mis;
                        o_mem_wdata <= acc_store ? st_wdata : '0;
                        o_mem_wstrb <= (acc_store && !acc_mis) ? st_strb : 4'b0000;
                        o_misalign  <= 1'b0;
                        o_wb_en     <= 1'b0;
                        if (!acc_load && !acc_store) begin
                            o_wb_data <= i_alu_res;
                            o_wb_en   <= i_rd_wen;
                            state     <= DONE;
                        end else if (acc_mis) begin
                            // Faulting address is left on o_wb_data for the trap handler.
                            o_wb_data  <= i_alu_res;
                            o_misalign <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (i_mem_gnt) begin
                        state <= (load_opt_q != '0) ? WAIT_R : DONE;
                    end
                end
                WAIT_R: begin
                    if (i_mem_rvalid) begin
                        o_wb_data <= ld_data;
                        o_wb_en   <= rd_wen_q;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_misalign <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_ready   = (state == IDLE);
    assign o_mem_req = (state == REQ);
    assign o_valid   = (state == DONE);
    assign state_dbg = state;

endmodule
